regbank_sb: RTL

Parametrised successor to the CPU register bank. It provides a zero-register-aware general-purpose register file with configurable width, depth and number of read ports. It also adds write-first bypass, a three-mode partial write (full / high-half / low-half), and an integrated pending-write scoreboard so the decode stage can detect RAW hazards. It sits between decode (reads, issue) and writeback (ALU or memory result) in the CPU pipeline.

---
 rtl/regbank_pkg.sv | 38 +++
 rtl/regbank_scoreboard.sv | 57 +++++
 rtl/regbank_sb.sv | 119 +++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared definitions for the parametrised register bank: writeback modes,
// default geometry and the half-word merge helper.
// No state; used by regbank_sb and regbank_scoreboard.
package regbank_pkg;

  // Writeback mode encodings carried on wb_mode
  typedef enum logic [1:0] {
    WB_FULL = 2'b00,
    WB_HIGH = 2'b01,
    WB_LOW  = 2'b10,
    WB_NONE = 2'b11
  } wb_mode_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 16;

  // Widest register the merge helper handles; DATA_W must not exceed it
  localparam int MAX_W = 64;

  // Merge the low half of new_v into either the high or low half of old_v.
  // w is the real register width; bits at and above w are expected to be 0.
  function automatic logic [MAX_W-1:0] merge_half(
    input logic [MAX_W-1:0] old_v,
    input logic [MAX_W-1:0] new_v,
    input logic             to_high,
    input int               w
  );
    logic [MAX_W-1:0] lo_mask;
    logic [MAX_W-1:0] half;
    lo_mask = {MAX_W{1'b1}} >> (MAX_W - w / 2);
    half    = new_v & lo_mask;
    if (to_high) begin
      return (old_v & ~(lo_mask << (w / 2))) | (half << (w / 2));
    end
    return (old_v & ~lo_mask) | half;
  endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one bit per register, RAW hazard detect on read ports.
// pending updates on the clock edge; hazard is combinational from current pending.
// No backpressure of its own; hazard is the stall request towards decode.
module regbank_scoreboard
  import regbank_pkg::*;
#(
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = 2,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NREGS-1:0]      pending,
  output logic                  hazard
);

  logic [NREGS-1:0] pending_nxt;

  // Next pending vector: writeback clears, issue sets afterwards so a
  // same-cycle issue (the newer instruction) wins; register 0 never pends.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid && wb_addr != '0) begin
      pending_nxt[wb_addr] = 1'b0;
    end
    if (iss_valid && iss_addr != '0) begin
      pending_nxt[iss_addr] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Pending state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Hazard if any non-zero read address is still waiting for its writeback.
  // Deliberately not bypassed by a same-cycle writeback.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*ADDR_W +: ADDR_W] != '0 && pending[rd_addr[i*ADDR_W +: ADDR_W]]) begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_sb.sv
// Register file with r0 hardwired to zero, NRD registered read ports,
// write-first bypass, full/high/low partial writeback and a pending scoreboard.
// Read latency 1 cycle; writes land at the edge; no backpressure (hazard stalls decode).
module regbank_sb
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = 2,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  input  logic                  wb_valid,
  input  logic [ADDR_W-1:0]     wb_addr,
  input  logic [1:0]            wb_mode,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  wb_mem,
  input  logic [DATA_W-1:0]     mem_q,
  input  logic                  iss_valid,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  hazard,
  output logic [NREGS-1:0]      pending
);

  logic [DATA_W-1:0] regs [NREGS];

  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  logic [MAX_W-1:0]  old_ext;
  logic [MAX_W-1:0]  new_ext;
  logic [MAX_W-1:0]  merged;
  logic [DATA_W-1:0] rd_nxt [NRD];

  assign old_ext = MAX_W'(regs[wb_addr]);
  assign new_ext = MAX_W'(wb_data);
  assign merged  = merge_half(old_ext, new_ext, wb_mode_e'(wb_mode) == WB_HIGH, DATA_W);

  // Resolve the effective write: memory loads always write the full word,
  // WB_NONE with an ALU result writes nothing, r0 is never a target.
  always_comb begin
    wr_en  = 1'b0;
    wr_val = regs[wb_addr];
    if (wb_valid && wb_addr != '0) begin
      if (wb_mem) begin
        wr_en  = 1'b1;
        wr_val = mem_q;
      end else begin
        case (wb_mode_e'(wb_mode))
          WB_FULL: begin
            wr_en  = 1'b1;
            wr_val = wb_data;
          end
          WB_HIGH, WB_LOW: begin
            wr_en  = 1'b1;
            wr_val = merged[DATA_W-1:0];
          end
          default: begin
            wr_en  = 1'b0;
          end
        endcase
      end
    end
  end

  // Register array update; entry 0 stays at its reset value of zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en) begin
      regs[wb_addr] <= wr_val;
    end
  end

  // Per-port read value with write-first bypass from the current writeback
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_nxt[i] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
      if (rd_addr[i*ADDR_W +: ADDR_W] == '0) begin
        rd_nxt[i] = '0;
      end else if (wr_en && rd_addr[i*ADDR_W +: ADDR_W] == wb_addr) begin
        rd_nxt[i] = wr_val;
      end
    end
  end

  // Registered read ports; hold their value while rd_en is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      for (int i = 0; i < NRD; i++) begin
        rd_data[i*DATA_W +: DATA_W] <= rd_nxt[i];
      end
    end
  end

  regbank_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .rd_addr   (rd_addr),
    .pending   (pending),
    .hazard    (hazard)
  );

endmodule
